// File: rtl/result_accumulator_pkg.sv
// Shared definitions for the result read-back path: FSM encodings and default widths,
// common with the multiply data mover.
package result_accumulator_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DEF_CNT           = 31;
  localparam int DEF_DWIDTH        = 32;
  localparam int DEF_AWIDTH        = 12;
  localparam int DEF_MEM_SIZE      = 4096;
  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH     = 48;

endpackage

// File: rtl/result_accumulator_rd_seq.sv
// Read sequencer: run/idle/done FSM, BRAM address counter and read-data valid tracking.
module result_rd_seq
  import result_accumulator_pkg::*;
#(
  parameter int CNT      = DEF_CNT,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [CNT-1:0]    i_num_cnt,
  output logic              o_idle,
  output logic              o_read,
  output logic              o_done,
  output logic              o_start,
  output logic              o_valid,
  output logic [AWIDTH-1:0] o_addr,
  output logic              o_ce
);

  // Power-of-two depth: masking is the same as letting the address wrap.
  localparam logic [AWIDTH-1:0] ADDR_MASK = AWIDTH'(MEM_SIZE - 1);

  logic [1:0]     r_state;
  logic [CNT-1:0] r_num_cnt;
  logic [CNT-1:0] r_addr_cnt;
  logic           r_valid;
  logic           w_last;

  assign w_last  = (r_addr_cnt == r_num_cnt - CNT'(1));
  assign o_start = (r_state == S_IDLE) && i_run;
  assign o_idle  = (r_state == S_IDLE);
  assign o_read  = (r_state == S_RUN);
  assign o_done  = (r_state == S_DONE);
  assign o_ce    = (r_state == S_RUN);
  assign o_valid = r_valid;
  assign o_addr  = r_addr_cnt[AWIDTH-1:0] & ADDR_MASK;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_num_cnt  <= '0;
      r_addr_cnt <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= o_ce;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_num_cnt  <= i_num_cnt;
            r_addr_cnt <= '0;
            r_state    <= (i_num_cnt == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_addr_cnt <= '0;
            r_state    <= S_DRAIN;
          end else begin
            r_addr_cnt <= r_addr_cnt + CNT'(1);
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/result_accumulator.sv
// Reads back the result BRAM and sums both packed products of every word into a wide
// accumulator with a sticky carry-out flag.
module result_accumulator
  import result_accumulator_pkg::*;
#(
  parameter int CNT           = DEF_CNT,
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int AWIDTH        = DEF_AWIDTH,
  parameter int MEM_SIZE      = DEF_MEM_SIZE,
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT-1:0]       i_num_cnt,
  output logic                 o_idle,
  output logic                 o_read,
  output logic                 o_done,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_overflow,
  output logic [AWIDTH-1:0]    addr_b1,
  output logic                 ce_b1,
  output logic                 we_b1,
  input  logic [DWIDTH-1:0]    q0_b1,
  output logic [DWIDTH-1:0]    d0_b1
);

  localparam int PW = 2 * IN_DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  logic                 w_start;
  logic                 w_valid;
  logic [SW-1:0]        w_prod [2];
  logic [SW-1:0]        w_acc_sum;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_overflow;

  result_rd_seq #(
    .CNT      (CNT),
    .AWIDTH   (AWIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_rd_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .o_idle    (o_idle),
    .o_read    (o_read),
    .o_done    (o_done),
    .o_start   (w_start),
    .o_valid   (w_valid),
    .o_addr    (addr_b1),
    .o_ce      (ce_b1)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_prod
      assign w_prod[gi] = SW'(q0_b1[gi*PW +: PW]);
    end
  endgenerate

  // One spare bit catches the carry out of the accumulator width.
  assign w_acc_sum = {1'b0, r_acc} + w_prod[0] + w_prod[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else if (w_valid) begin
      r_acc <= w_acc_sum[ACC_WIDTH-1:0];
      if (w_acc_sum[ACC_WIDTH]) r_overflow <= 1'b1;
    end
  end

  assign o_sum      = r_acc;
  assign o_overflow = r_overflow;
  assign we_b1      = 1'b0;
  assign d0_b1      = '0;

endmodule
